seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 55 +++++
 rtl/scan_stabilizer.sv | 54 +++++
 rtl/seg_scan_decoder.sv | 197 +++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and glyph decoding for the 7-segment scan decoder.
// Segment patterns are active-low {a,b,c,d,e,f,g}.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } scan_state_e;

    localparam int NUM_POS = 8;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // Returns {valid, value}; unknown patterns decode as 4'hF with valid=0.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            GLYPH_0: r = {1'b1, 4'h0};
            GLYPH_1: r = {1'b1, 4'h1};
            GLYPH_2: r = {1'b1, 4'h2};
            GLYPH_3: r = {1'b1, 4'h3};
            GLYPH_4: r = {1'b1, 4'h4};
            GLYPH_5: r = {1'b1, 4'h5};
            GLYPH_6: r = {1'b1, 4'h6};
            GLYPH_7: r = {1'b1, 4'h7};
            GLYPH_8: r = {1'b1, 4'h8};
            GLYPH_9: r = {1'b1, 4'h9};
            GLYPH_A: r = {1'b1, 4'hA};
            GLYPH_B: r = {1'b1, 4'hB};
            GLYPH_C: r = {1'b1, 4'hC};
            GLYPH_D: r = {1'b1, 4'hD};
            GLYPH_E: r = {1'b1, 4'hE};
            GLYPH_F: r = {1'b1, 4'hF};
            default: r = {1'b0, 4'hF};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scan_stabilizer.sv
// Two-flop synchronizer plus hold filter: emits one accept strobe once the
// synced word has been steady for STABLE_CYCLES cycles, re-armed by any change.
module scan_stabilizer #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             accept_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync2_q, hold_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept_q, accept_d;
    logic             same;

    always_comb begin
        same = (sync2_q == hold_q);
        if (!same) begin
            cnt_d = CW'(1);
        end else if (cnt_q == HOLD_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        accept_d = (cnt_d == HOLD_MAX) && (!same || cnt_q != HOLD_MAX);
    end

    // Reset to an idle (all-off) bus with the counter saturated so no strobe fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            hold_q   <= '1;
            cnt_q    <= HOLD_MAX;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= data_i;
            sync2_q  <= sync1_q;
            hold_q   <= sync2_q;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    assign data_o   = hold_q;
    assign accept_o = accept_q;

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive reader of the multiplexed 7-segment bus; publishes all 8 positions
// once per scan frame. Optional counters enabled by SEG_SCAN_STATS_EN.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [7:0]  dec_cat,
    output logic [31:0] digits,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_dp,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        active
`ifdef SEG_SCAN_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    import seg_scan_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [15:0] smp;
    logic        acc;

    scan_stabilizer #(
        .WIDTH         (16),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clock    (clock),
        .reset    (reset),
        .data_i   ({an, dec_cat}),
        .data_o   (smp),
        .accept_o (acc)
    );

    logic [7:0] smp_an, smp_cat;
    logic [2:0] idx;
    logic [4:0] lut;
    logic       blank, one_cold, digit_ok, new_err;

    assign smp_an   = smp[15:8];
    assign smp_cat  = smp[7:0];
    assign blank    = (smp_an == 8'hFF);
    assign one_cold = $onehot(~smp_an);
    assign lut      = seg_to_hex(smp_cat[7:1]);
    assign digit_ok = acc && one_cold;
    assign new_err  = acc && !blank && (!one_cold || !lut[4]);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (!smp_an[i]) idx = 3'(i);
        end
    end

    scan_state_e     state_q, state_d;
    logic [TW-1:0]   tmo_q;
    logic            tmo_hit;
    logic            do_store, do_pub, do_clear;
    logic [2:0]      last_idx_q;
    logic [7:0][3:0] shadow_val_q;
    logic [7:0]      shadow_dp_q, seen_q;
    logic            err_q;
    logic [31:0]     digits_q;
    logic [7:0]      dig_en_q, dig_dp_q;
    logic            seg_err_q, active_q;

    assign tmo_hit = (tmo_q == TMO_MAX);

    // A digit at or below the last index means the scan wrapped: publish the
    // collected frame and let the wrapping digit open the next one.
    always_comb begin
        state_d  = state_q;
        do_store = 1'b0;
        do_pub   = 1'b0;
        do_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (digit_ok) begin
                    do_store = 1'b1;
                    state_d  = COLLECT;
                end
            end
            COLLECT, PUBLISH: begin
                state_d = COLLECT;
                if (digit_ok) begin
                    do_store = 1'b1;
                    if (idx <= last_idx_q) begin
                        do_pub  = 1'b1;
                        state_d = PUBLISH;
                    end
                end else if (tmo_hit) begin
                    do_clear = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q        <= '0;
            last_idx_q   <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seen_q       <= '0;
            err_q        <= 1'b0;
            digits_q     <= '0;
            dig_en_q     <= '0;
            dig_dp_q     <= '0;
            seg_err_q    <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            if (digit_ok) begin
                tmo_q <= '0;
            end else if (!tmo_hit) begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (do_clear) begin
                shadow_val_q <= '0;
                shadow_dp_q  <= '0;
                seen_q       <= '0;
                err_q        <= 1'b0;
                digits_q     <= '0;
                dig_en_q     <= '0;
                dig_dp_q     <= '0;
                seg_err_q    <= 1'b0;
                active_q     <= 1'b0;
            end else begin
                if (do_pub) begin
                    for (int i = 0; i < NUM_POS; i++) begin
                        digits_q[4*i +: 4] <= seen_q[i] ? shadow_val_q[i] : 4'h0;
                        dig_dp_q[i]        <= seen_q[i] & shadow_dp_q[i];
                    end
                    dig_en_q  <= seen_q;
                    seg_err_q <= err_q;
                    active_q  <= 1'b1;
                    seen_q    <= '0;
                    err_q     <= new_err;
                end else if (new_err) begin
                    err_q <= 1'b1;
                end
                if (do_store) begin
                    seen_q[idx]       <= 1'b1;
                    shadow_val_q[idx] <= lut[3:0];
                    shadow_dp_q[idx]  <= ~smp_cat[0];
                    last_idx_q        <= idx;
                end
            end
        end
    end

    assign digits      = digits_q;
    assign dig_en      = dig_en_q;
    assign dig_dp      = dig_dp_q;
    assign seg_err     = seg_err_q;
    assign active      = active_q;
    assign frame_valid = (state_q == PUBLISH);

`ifdef SEG_SCAN_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    // Counters survive timeout; only reset clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (do_pub && !do_clear) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_q && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: scans are driven on the bus, expected
// frames queued, and a monitor compares every frame_valid against the queue.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 1000;
    localparam int DWELL  = 20;
    localparam int FW     = 50;

    localparam logic [31:0] A_VALS = 32'h7654_3210;
    localparam logic [7:0]  A_DP   = 8'h04;
    localparam logic [31:0] B_VALS = 32'h0000_FA89;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  an = 8'hFF;
    logic [7:0]  dec_cat = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  dig_en, dig_dp;
    logic        frame_valid, seg_err, active;
`ifdef SEG_SCAN_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] mon_exp;

    seg_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .an          (an),
        .dec_cat     (dec_cat),
        .digits      (digits),
        .dig_en      (dig_en),
        .dig_dp      (dig_dp),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .active      (active)
`ifdef SEG_SCAN_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive_raw(input logic [7:0] a, input logic [7:0] c, input int cycles);
        an      = a;
        dec_cat = c;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic drive_digit(input int pos, input logic [3:0] v, input logic dp);
        logic [7:0] a;
        a = 8'h01 << pos;
        drive_raw(~a, {glyph(v), ~dp}, DWELL);
    endtask

    // bad_pos: position shows segment g only; multi_before: multi-hot anode
    // inserted just before that position (-1 disables either).
    task automatic drive_scan(input logic [31:0] vals, input logic [7:0] dps, input int npos,
                              input bit glitch, input int bad_pos, input int multi_before);
        logic [7:0] a;
        for (int i = 0; i < npos; i++) begin
            if (glitch) drive_raw(8'hBF, {glyph(4'h8), 1'b1}, 2);
            if (i == multi_before) drive_raw(8'hFC, {glyph(4'h8), 1'b1}, DWELL);
            if (i == bad_pos) begin
                a = 8'h01 << i;
                drive_raw(~a, 8'b1111_1101, DWELL);
            end else begin
                drive_digit(i, vals[4*i +: 4], dps[i]);
            end
        end
    endtask

    task automatic expect_frame(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp,
                                input logic err);
        exp_q.push_back({d, en, dp, err, 1'b1});
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clock);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_digits"}, digits, 32'h0);
        check({tag, "_dig_en"}, {24'h0, dig_en}, 32'h0);
        check({tag, "_dig_dp"}, {24'h0, dig_dp}, 32'h0);
        check({tag, "_frame_valid"}, {31'h0, frame_valid}, 32'h0);
        check({tag, "_seg_err"}, {31'h0, seg_err}, 32'h0);
        check({tag, "_active"}, {31'h0, active}, 32'h0);
    endtask

    always @(negedge clock) begin
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: got digits=%h dig_en=%h, required no frame",
                         digits, dig_en);
            end else begin
                mon_exp = exp_q.pop_front();
                check("frame_digits", digits, mon_exp[49:18]);
                check("frame_dig_en", {24'h0, dig_en}, {24'h0, mon_exp[17:10]});
                check("frame_dig_dp", {24'h0, dig_dp}, {24'h0, mon_exp[9:2]});
                check("frame_seg_err", {31'h0, seg_err}, {31'h0, mon_exp[1]});
                check("frame_active", {31'h0, active}, {31'h0, mon_exp[0]});
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_cleared("reset");
        reset = 1'b0;
        repeat (5) @(negedge clock);

        expect_frame(A_VALS, 8'hFF, A_DP, 1'b0);
        drive_scan(A_VALS, A_DP, 8, 1'b0, -1, -1);
        expect_frame(A_VALS, 8'hFF, A_DP, 1'b0);
        drive_scan(A_VALS, A_DP, 8, 1'b0, -1, -1);

        expect_frame(B_VALS, 8'h0F, 8'h00, 1'b0);
        drive_scan(B_VALS, 8'h00, 4, 1'b0, -1, -1);
        expect_frame(B_VALS, 8'h0F, 8'h00, 1'b0);
        drive_scan(B_VALS, 8'h00, 4, 1'b0, -1, -1);

        expect_frame(A_VALS, 8'hFF, A_DP, 1'b0);
        drive_scan(A_VALS, A_DP, 8, 1'b1, -1, -1);

        expect_frame(32'h765F_3210, 8'hFF, A_DP, 1'b1);
        drive_scan(A_VALS, A_DP, 8, 1'b0, 4, -1);
        expect_frame(A_VALS, 8'hFF, A_DP, 1'b0);
        drive_scan(A_VALS, A_DP, 8, 1'b0, -1, -1);

        expect_frame(A_VALS, 8'hFF, A_DP, 1'b1);
        drive_scan(A_VALS, A_DP, 8, 1'b0, -1, 4);
        expect_frame(A_VALS, 8'hFF, A_DP, 1'b0);
        drive_scan(A_VALS, A_DP, 8, 1'b0, -1, -1);

        drive_digit(0, 4'h0, 1'b0);
        drive_raw(8'hFF, 8'hFF, 1);
        wait_drain(200);
        check("drain_before_timeout", exp_q.size(), 32'd0);
        check("active_before_timeout", {31'h0, active}, 32'h1);

        repeat (TMO + 100) @(negedge clock);
        check_cleared("timeout");

        expect_frame(A_VALS, 8'hFF, A_DP, 1'b0);
        drive_scan(A_VALS, A_DP, 8, 1'b0, -1, -1);
        drive_scan(A_VALS, A_DP, 3, 1'b0, -1, -1);
        drive_raw(8'hF7, {glyph(4'h3), 1'b1}, 10);
        check("restart_frame_published", exp_q.size(), 32'd0);
        reset = 1'b1;
        #1;
        check("reset_mid_digits", digits, 32'h0);
        check("reset_mid_dig_en", {24'h0, dig_en}, 32'h0);
        check("reset_mid_active", {31'h0, active}, 32'h0);
        an      = 8'hFF;
        dec_cat = 8'hFF;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        expect_frame(B_VALS, 8'h0F, 8'h00, 1'b0);
        drive_scan(B_VALS, 8'h00, 4, 1'b0, -1, -1);
        expect_frame(B_VALS, 8'h0F, 8'h00, 1'b0);
        drive_scan(B_VALS, 8'h00, 4, 1'b0, -1, -1);
        drive_digit(0, 4'h9, 1'b0);
        drive_raw(8'hFF, 8'hFF, 1);
        wait_drain(200);
        check("final_drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
